dma_mem_responder: RTL and testbench
====================================

# dma_mem_responder

Memory-side responder for the `data_*` port of the DMA core (`ucore_main`). It accepts single-word read and write requests from the DMA initiator. Requests are served from an internal word-addressed RAM mapped at a fixed base address, with a configurable number of wait states. It replaces the bench-level `data_en`/`data_rdata` stub, so DMA transfers can be checked end to end: data written to the destination must equal data read from the source.

## Interface
- `BASE_ADDR`, 32'h4000_0000, byte address of RAM word 0.
- `DEPTH_LOG2`, 8, RAM depth is 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, 0, extra wait cycles per access (0..15).
- `clk`  in  1  single clock, rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `data_valid`  in  1  initiator request; held high with fields stable until `data_en`.
- `data_w_en`  in  1  1 = write, 0 = read; sampled with `data_valid`.
- `data_addr`  in  32  byte address, word aligned.
- `data_wdata`  in  32  write data.
- `data_en`  out  1  one-cycle completion pulse.
- `data_rdata`  out  32  read data; valid only while `data_en` is high, 0 otherwise.
- `data_err`  out  1  high with `data_en` when the access was out of range or misaligned.
- `rd_count`  out  16  count of completed reads, wraps.
- `wr_count`  out  16  count of completed writes, wraps.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On `data_valid`=1, capture `data_addr`, `data_w_en` and `data_wdata`, and load the wait counter with `LATENCY`.
  - Go to WAIT if `LATENCY`>0, otherwise go to RESP.
- WAIT: decrement the counter; go to RESP when the counter reaches 1.
- RESP:
  - `data_en`=1 for exactly one cycle, then return to IDLE.
  - `data_valid` is ignored while in WAIT and RESP.
- Decode:
  - offset = addr − `BASE_ADDR`, a 32-bit unsigned subtraction, so addresses below the base wrap to large values and fail the range check.
  - In range when offset < 4·2^DEPTH_LOG2 and addr[1:0]==0.
  - Word index = offset[DEPTH_LOG2+1:2].
- Write:
  - The RAM word is updated on the edge that enters RESP.
  - Out-of-range or misaligned writes are dropped and set `data_err`.
- Read:
  - `data_rdata` = RAM[index] during RESP.
  - Out-of-range or misaligned reads return 32'h0 and set `data_err`.
- Counters increment on the RESP cycle by request type, whether or not `data_err` is set. They wrap from 16'hFFFF to 0.
- RAM contents are not reset. They are undefined after power-up and preserved across `areset`.

## Timing
- Reset values: state IDLE, `data_en`=0, `data_rdata`=0, `data_err`=0, `rd_count`=0, `wr_count`=0.
- Latency: a request first seen in IDLE at edge N produces `data_en` during cycle N+1+`LATENCY`. With `LATENCY`=0 this is one cycle.
- Back-to-back requests:
  - If `data_valid` is still high in the cycle after RESP, it is a new request and is captured in IDLE.
  - Minimum spacing is 2+`LATENCY` cycles per access.
- Hazards:
  - A read following a write to the same word returns the new data.
  - There is no read-during-write hazard, because only one access is in flight at a time.
- Reset mid-access:
  - `areset` during WAIT or RESP forces IDLE immediately; `data_en`, `data_err` and `data_rdata` drop asynchronously.
  - A write whose RESP-entry edge has not occurred is not committed.
  - Counters clear.
- `data_valid` dropping early (before `data_en`) is a protocol violation. The access still completes on the captured fields.

## Test plan
- Write 32'hA5A5_0001 to 32'h4000_0010, then read 32'h4000_0010 with `LATENCY`=0. Required response:
  - write `data_en` one cycle after capture;
  - read returns 32'hA5A5_0001;
  - `wr_count`=1, `rd_count`=1, `data_err`=0.
- `LATENCY`=3, read 32'h4000_0000. Required response:
  - `data_en` exactly 4 cycles after capture and high for one cycle;
  - `data_rdata`=0 in every other cycle.
- Read 32'h3FFF_FFFC, read 32'h4000_0400 (DEPTH_LOG2=8), and write 32'h4000_0002. Required response:
  - each access gives `data_err`=1;
  - reads return 0;
  - a later read of word 0 is unchanged.
- DMA end to end: connect `ucore_main` and preload words 0..4 at 32'h4000_0000 with 1..5. Run the transfer src 32'h4000_0000, dst 32'h4000_0100, count 5. Required response:
  - words at 32'h4000_0100..0110 equal 1..5;
  - `rd_count`=5, `wr_count`=5 at `ctrl_finished`.
- Assert `areset` during WAIT of a write to 32'h4000_0020 (`LATENCY`=4). Required response:
  - `data_en` is never pulsed for that access;
  - the word keeps its old value;
  - counters read 0.
- Hold `data_valid` high for 4 consecutive reads with `LATENCY`=0. Required response:
  - `data_en` pulses every 2 cycles;
  - `rd_count`=4.

Source files
------------

// File: rtl/dma_mem_responder_if.sv
// Single-word request/response bus between a DMA initiator and a memory responder.
// The initiator holds data_valid and the request fields stable until data_en pulses.
interface dma_mem_responder_if;
  logic        data_valid;
  logic        data_w_en;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_en;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_valid, data_w_en, data_addr, data_wdata,
    input  data_en, data_rdata, data_err
  );

  modport slave (
    input  data_valid, data_w_en, data_addr, data_wdata,
    output data_en, data_rdata, data_err
  );
endinterface

// File: rtl/dma_mem_responder.sv
// Memory-side responder for the DMA data port: one access in flight, served from an
// internal word RAM at BASE_ADDR after LATENCY wait cycles, with range/alignment errors.
module dma_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          DEPTH_LOG2 = 8,
  parameter int          LATENCY    = 0
) (
  input  logic               clk,
  input  logic               areset,
  dma_mem_responder_if.slave bus,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic        err_q, err_d;
  logic [15:0] rd_count_q, wr_count_q;

  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [31:0]           req_offset;
  logic                  req_wen;
  logic                  req_ok;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  enter_resp;
  logic                  mem_we;

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_rd_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wen_d      = wen_q;
    err_d      = err_q;
    req_addr   = addr_q;
    req_wdata  = wdata_q;
    req_wen    = wen_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          addr_d    = bus.data_addr;
          wdata_d   = bus.data_wdata;
          wen_d     = bus.data_w_en;
          cnt_d     = LAT;
          // With no wait states the request goes straight to RESP on the capture edge,
          // so decode must look at the live bus fields rather than the registers.
          req_addr  = bus.data_addr;
          req_wdata = bus.data_wdata;
          req_wen   = bus.data_w_en;
          if (LATENCY > 0) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Unsigned wrap makes addresses below the base land far outside the window.
    req_offset = req_addr - BASE_ADDR;
    req_ok     = ({1'b0, req_offset} < SPAN) && (req_addr[1:0] == 2'b00);
    req_idx    = req_offset[DEPTH_LOG2+1:2];
    if (enter_resp) begin
      err_d = ~req_ok;
    end
    mem_we = enter_resp && req_wen && req_ok && !areset;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
      if (state_q == RESP) begin
        if (wen_q) begin
          wr_count_q <= wr_count_q + 16'd1;
        end else begin
          rd_count_q <= rd_count_q + 16'd1;
        end
      end
    end
  end

  // RAM is deliberately outside the reset domain; the read register captures the
  // addressed word on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req_idx] <= req_wdata;
    end
    mem_rd_q <= mem[req_idx];
  end

  assign bus.data_en    = (state_q == RESP);
  assign bus.data_err   = (state_q == RESP) && err_q;
  assign bus.data_rdata = ((state_q == RESP) && !wen_q && !err_q) ? mem_rd_q : 32'h0;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Bench for dma_mem_responder: three instances (LATENCY 0, 3, 4) driven by directed and
// random accesses, checked against a word-array model of the memory window.
module tb_dma_mem_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        vld   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  wire         en_w    [3];
  wire         err_w   [3];
  wire  [31:0] rdata_w [3];
  wire  [15:0] rdc     [3];
  wire  [15:0] wrc     [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dma_mem_responder_if ifc ();
    assign ifc.data_valid = vld[gi];
    assign ifc.data_w_en  = wen[gi];
    assign ifc.data_addr  = addr[gi];
    assign ifc.data_wdata = wdata[gi];
    assign en_w[gi]    = ifc.data_en;
    assign err_w[gi]   = ifc.data_err;
    assign rdata_w[gi] = ifc.data_rdata;

    dma_mem_responder #(
      .BASE_ADDR (BASE),
      .DEPTH_LOG2(8),
      .LATENCY   ((gi == 0) ? 0 : (gi == 1) ? 3 : 4)
    ) u_dut (
      .clk     (clk),
      .areset  (rst[gi]),
      .bus     (ifc.slave),
      .rd_count(rdc[gi]),
      .wr_count(wrc[gi])
    );
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [3][256];
  bit          ref_ok  [3][256];
  logic [15:0] rd_exp  [3];
  logic [15:0] wr_exp  [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 4;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd1024) && (a % 4 == 0);
  endfunction

  // One protocol-compliant access: hold valid until data_en, then release it.
  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int cyc;
    bit seen;
    @(negedge clk);
    vld[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk);
    cyc = 0; seen = 1'b0; rd = '0; er = 1'b0;
    while (!seen && cyc < 40) begin
      #1;
      if (en_w[k]) begin
        seen = 1'b1; rd = rdata_w[k]; er = err_w[k]; vld[k] = 1'b0;
      end else begin
        chk("rdata_idle", rdata_w[k], 32'h0);
        @(posedge clk);
        cyc++;
      end
    end
    vld[k] = 1'b0;
    lat = cyc + 1;
    chk("en_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    chk("en_one_cycle", 32'(en_w[k]), 32'd0);
    chk("rdata_after", rdata_w[k], 32'h0);
  endtask

  task automatic op(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] rd_o);
    logic er;
    int   lat;
    bit   ok;
    int   ix;
    ok = in_rng(a);
    ix = ok ? int'((a - BASE) >> 2) : 0;
    access(k, w, a, d, rd_o, er, lat);
    if (w) wr_exp[k] = wr_exp[k] + 16'd1;
    else   rd_exp[k] = rd_exp[k] + 16'd1;
    if (w && ok) begin
      ref_mem[k][ix] = d;
      ref_ok[k][ix]  = 1'b1;
    end
    chk("err", 32'(er), 32'(!ok));
    chk("latency", 32'(lat), 32'(1 + lat_of(k)));
    if (!w) begin
      if (!ok)              chk("rdata_oor", rd_o, 32'h0);
      else if (ref_ok[k][ix]) chk("rdata", rd_o, ref_mem[k][ix]);
    end
    chk("rd_count", 32'(rdc[k]), 32'(rd_exp[k]));
    chk("wr_count", 32'(wrc[k]), 32'(wr_exp[k]));
    $display("xfer inst=%0d %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             k, w ? "WR" : "RD", a, d, rd_o, er, lat);
  endtask

  logic [31:0] rv;
  logic [31:0] ra;
  logic [15:0] rc0, wc0;
  int          n, cyc, last, pulses;
  bit          seen;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; vld[k] = 1'b0; wen[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      rd_exp[k] = '0; wr_exp[k] = '0;
      for (int j = 0; j < 256; j++) begin
        ref_ok[k][j] = 1'b0; ref_mem[k][j] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_en",    32'(en_w[k]),  32'd0);
      chk("rst_err",   32'(err_w[k]), 32'd0);
      chk("rst_rdata", rdata_w[k],    32'h0);
      chk("rst_rdc",   32'(rdc[k]),   32'd0);
      chk("rst_wrc",   32'(wrc[k]),   32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Basic write then read-back, no wait states.
    op(0, 1'b1, 32'h4000_0010, 32'hA5A5_0001, rv);
    op(0, 1'b0, 32'h4000_0010, 32'h0, rv);
    chk("t1_rdata", rv, 32'hA5A5_0001);

    // Three wait states.
    op(1, 1'b1, 32'h4000_0000, 32'h1234_5678, rv);
    op(1, 0, 32'h4000_0000, 32'h0, rv);
    chk("t2_rdata", rv, 32'h1234_5678);

    // Error cases leave word 0 untouched.
    op(0, 1'b1, 32'h4000_0000, 32'hCAFE_0000, rv);
    op(0, 1'b0, 32'h3FFF_FFFC, 32'h0, rv);
    op(0, 1'b0, 32'h4000_0400, 32'h0, rv);
    op(0, 1'b1, 32'h4000_0002, 32'hBAD0_BAD0, rv);
    op(0, 1'b0, 32'h4000_0000, 32'h0, rv);
    chk("t3_word0", rv, 32'hCAFE_0000);

    // Random mix on the LATENCY 0 and 3 instances.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(9, 0));
      if (r < 8)       ra = BASE + 32'(4 * $urandom_range(15, 0));
      else if (r == 8) ra = $urandom;
      else             ra = BASE + 32'(4 * $urandom_range(255, 0)) + 32'($urandom_range(3, 1));
      op(i % 2, 1'($urandom_range(1, 0)), ra, $urandom, rv);
    end

    // DMA-style copy of five words, 0x4000_0000 -> 0x4000_0100.
    for (int i = 0; i < 5; i++) op(0, 1'b1, BASE + 32'(4 * i), 32'(i + 1), rv);
    rc0 = rd_exp[0]; wc0 = wr_exp[0];
    for (int i = 0; i < 5; i++) begin
      op(0, 1'b0, BASE + 32'(4 * i), 32'h0, rv);
      op(0, 1'b1, BASE + 32'h100 + 32'(4 * i), rv, ra);
    end
    chk("dma_rd_count", 32'(rdc[0] - rc0), 32'd5);
    chk("dma_wr_count", 32'(wrc[0] - wc0), 32'd5);
    for (int i = 0; i < 5; i++) begin
      op(0, 1'b0, BASE + 32'h100 + 32'(4 * i), 32'h0, rv);
      chk("dma_dst", rv, 32'(i + 1));
    end

    // Back-to-back reads with valid held high.
    rc0 = rd_exp[0];
    @(negedge clk);
    vld[0] = 1'b1; wen[0] = 1'b0; addr[0] = BASE;
    @(posedge clk);
    n = 0; cyc = 0; last = 0;
    while (n < 4 && cyc < 40) begin
      #1;
      if (en_w[0]) begin
        chk("bb_rdata", rdata_w[0], 32'(n + 1));
        if (n > 0) chk("bb_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        n++;
        if (n < 4) addr[0] = BASE + 32'(4 * n);
        else       vld[0] = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    vld[0] = 1'b0;
    chk("bb_done", 32'(n), 32'd4);
    rd_exp[0] = rd_exp[0] + 16'd4;
    #1;
    chk("bb_rd_count", 32'(rdc[0] - rc0), 32'd4);
    $display("xfer inst=0 back-to-back reads=%0d", n);

    // Reset during WAIT of a write: nothing committed, counters clear.
    op(2, 1'b1, 32'h4000_0020, 32'h1111_2222, rv);
    @(negedge clk);
    vld[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h4000_0020; wdata[2] = 32'hDEAD_BEEF;
    @(posedge clk);
    pulses = 0;
    repeat (2) begin
      #1;
      if (en_w[2]) pulses++;
      @(posedge clk);
    end
    #1;
    rst[2] = 1'b1; vld[2] = 1'b0;
    #1;
    chk("wait_rst_en", 32'(en_w[2]), 32'd0);
    repeat (6) begin
      @(posedge clk);
      #1;
      if (en_w[2]) pulses++;
    end
    @(negedge clk);
    rst[2] = 1'b0;
    rd_exp[2] = '0; wr_exp[2] = '0;
    chk("wait_rst_pulses", 32'(pulses), 32'd0);
    chk("wait_rst_rdc", 32'(rdc[2]), 32'd0);
    chk("wait_rst_wrc", 32'(wrc[2]), 32'd0);
    $display("xfer inst=2 WR aborted by reset pulses=%0d", pulses);
    op(2, 1'b0, 32'h4000_0020, 32'h0, rv);
    chk("wait_rst_word", rv, 32'h1111_2222);

    // Reset in the middle of a RESP cycle drops the outputs at once.
    @(negedge clk);
    vld[1] = 1'b1; wen[1] = 1'b0; addr[1] = 32'h4000_0400;
    @(posedge clk);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      #1;
      if (en_w[1]) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    vld[1] = 1'b0;
    chk("resp_seen", 32'(seen), 32'd1);
    chk("resp_err_pre", 32'(err_w[1]), 32'd1);
    #1;
    rst[1] = 1'b1;
    #1;
    chk("resp_rst_en", 32'(en_w[1]), 32'd0);
    chk("resp_rst_err", 32'(err_w[1]), 32'd0);
    chk("resp_rst_rdata", rdata_w[1], 32'h0);
    chk("resp_rst_rdc", 32'(rdc[1]), 32'd0);
    chk("resp_rst_wrc", 32'(wrc[1]), 32'd0);
    $display("xfer inst=1 RD reset during RESP");
    @(negedge clk);
    rst[1] = 1'b0;
    rd_exp[1] = '0; wr_exp[1] = '0;
    op(1, 1'b0, 32'h4000_0000, 32'h0, rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
